// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared arbiter state encoding and stream data width
package stream_pkg;

    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - output holding register; source tag under STREAM_ARB_SRC_TAG_EN
module stream_reg_slice
    import stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_ld_data,
`ifdef STREAM_ARB_SRC_TAG_EN
    input  logic              i_ld_src,
    output logic              o_src,
`endif
    input  logic              i_out_rdy,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Data carries no reset: it is only meaningful while r_valid is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_ld) begin
            r_valid <= 1'b1;
            r_data  <= i_ld_data;
        end else if (i_out_rdy) begin
            r_valid <= 1'b0;
        end
    end

`ifdef STREAM_ARB_SRC_TAG_EN
    logic r_src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src <= 1'b0;
        end else if (i_ld) begin
            r_src <= i_ld_src;
        end
    end

    assign o_src = r_src;
`endif

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_arb2.sv
// rtl/stream_arb2.sv - two-source round-robin burst arbiter; optional s1o_src via STREAM_ARB_SRC_TAG_EN
module stream_arb2
    import stream_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0i_valid,
    output logic              s0i_rdy,
    input  logic [DATA_W-1:0] s0i_data,
    input  logic              s1i_valid,
    output logic              s1i_rdy,
    input  logic [DATA_W-1:0] s1i_data,
`ifdef STREAM_ARB_SRC_TAG_EN
    output logic              s1o_src,
`endif
    output logic              s1o_valid,
    input  logic              s1o_rdy,
    output logic [DATA_W-1:0] s1o_data
);

    arb_state_t r_state, w_state_nxt;
    logic       r_rr, w_rr_nxt;
    logic [7:0] r_beat_cnt, w_beat_cnt_nxt;
    logic       w_out_free;
    logic       w_rdy0, w_rdy1;
    logic       w_acc0, w_acc1;
    logic       w_last;

    assign w_out_free = ~s1o_valid | s1o_rdy;
    assign w_last     = (r_beat_cnt == 8'(BURST_MAX - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rdy0         = 1'b0;
        w_rdy1         = 1'b0;
        case (r_state)
            IDLE: begin
                w_beat_cnt_nxt = 8'd0;
                if (s0i_valid && (!s1i_valid || !r_rr)) begin
                    w_state_nxt = GNT0;
                end else if (s1i_valid) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                w_rdy0 = w_out_free;
                if (s0i_valid && w_out_free) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = 1'b1;
                    end
                end else if (w_out_free) begin
                    // Source went idle while it could have sent: release early.
                    w_state_nxt = IDLE;
                    w_rr_nxt    = 1'b1;
                end
            end
            GNT1: begin
                w_rdy1 = w_out_free;
                if (s1i_valid && w_out_free) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = 1'b0;
                    end
                end else if (w_out_free) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr       <= 1'b0;
            r_beat_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Ready is masked during reset so no handshake completes on a reset edge.
    assign s0i_rdy = rst_n & w_rdy0;
    assign s1i_rdy = rst_n & w_rdy1;
    assign w_acc0  = s0i_valid & s0i_rdy;
    assign w_acc1  = s1i_valid & s1i_rdy;

    stream_reg_slice u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ld      (w_acc0 | w_acc1),
        .i_ld_data (w_acc1 ? s1i_data : s0i_data),
`ifdef STREAM_ARB_SRC_TAG_EN
        .i_ld_src  (w_acc1),
        .o_src     (s1o_src),
`endif
        .i_out_rdy (s1o_rdy),
        .o_valid   (s1o_valid),
        .o_data    (s1o_data)
    );

endmodule

// File: tb/tb_stream_arb2.sv
// tb/tb_stream_arb2.sv - directed self-checking bench for stream_arb2
module tb_stream_arb2;
    import stream_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s0i_valid, s0i_rdy;
    logic [127:0] s0i_data;
    logic         s1i_valid, s1i_rdy;
    logic [127:0] s1i_data;
    logic         s1o_valid, s1o_rdy;
    logic [127:0] s1o_data;
`ifdef STREAM_ARB_SRC_TAG_EN
    logic         s1o_src;
`endif

    int           errors = 0;
    int           checks = 0;
    int           d0, d1;
    logic [127:0] out_q[$];
    logic         src_q[$];
    logic         last_v;
    logic [127:0] last_d;

    always #5 clk = ~clk;

    stream_arb2 #(.BURST_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0i_valid (s0i_valid),
        .s0i_rdy   (s0i_rdy),
        .s0i_data  (s0i_data),
        .s1i_valid (s1i_valid),
        .s1i_rdy   (s1i_rdy),
        .s1i_data  (s1i_data),
`ifdef STREAM_ARB_SRC_TAG_EN
        .s1o_src   (s1o_src),
`endif
        .s1o_valid (s1o_valid),
        .s1o_rdy   (s1o_rdy),
        .s1o_data  (s1o_data)
    );

    // One clock: sample at negedge, advance source data on accepted beats after posedge.
    task automatic cyc();
        logic a0, a1;
        @(negedge clk);
        last_v = s1o_valid;
        last_d = s1o_data;
        if (s1o_valid && s1o_rdy) begin
            out_q.push_back(s1o_data);
`ifdef STREAM_ARB_SRC_TAG_EN
            src_q.push_back(s1o_src);
`else
            src_q.push_back(1'b0);
`endif
        end
        a0 = s0i_valid && s0i_rdy;
        a1 = s1i_valid && s1i_rdy;
        @(posedge clk);
        #1;
        if (a0) begin d0++; s0i_data = 128'(d0); end
        if (a1) begin d1++; s1i_data = 128'(d1); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s0i_valid = 1'b0; s1i_valid = 1'b0; s1o_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_q.delete();
        src_q.delete();
    endtask

    task automatic set_src(input int b0, input int b1);
        d0 = b0; d1 = b1;
        s0i_data = 128'(d0);
        s1i_data = 128'(d1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s0i_valid = 1'b1; s1i_valid = 1'b1; s1o_rdy = 1'b1;
        set_src(1, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s0i_rdy !== 1'b0) begin errors++; $display("FAIL reset_s0_rdy got %b want 0", s0i_rdy); end
        checks++; if (s1i_rdy !== 1'b0) begin errors++; $display("FAIL reset_s1_rdy got %b want 0", s1i_rdy); end
        checks++; if (s1o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s1o_valid); end
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", dut.r_state); end
        checks++; if (dut.r_rr !== 1'b0) begin errors++; $display("FAIL reset_rr got %b want 0", dut.r_rr); end
        checks++; if (dut.r_beat_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.r_beat_cnt); end
    endtask

    task automatic test_single();
        bit exp_v[12] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int exp_d[12] = '{0, 0, 1, 2, 3, 4, 0, 5, 6, 7, 8, 0};
        do_reset();
        set_src(1, 0);
        s0i_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            checks++;
            if (last_v !== exp_v[c]) begin
                errors++; $display("FAIL single_valid cycle %0d got %b want %b", c + 1, last_v, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (last_d !== 128'(exp_d[c])) begin
                    errors++; $display("FAIL single_data cycle %0d got %0h want %0h", c + 1, last_d, exp_d[c]);
                end
            end
        end
        s0i_valid = 1'b0;
    endtask

    task automatic test_both();
        int exp_d[12] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hB0, 'hB1, 'hB2, 'hB3, 'hA4, 'hA5, 'hA6, 'hA7};
        bit exp_s[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        do_reset();
        set_src('hA0, 'hB0);
        s0i_valid = 1'b1; s1i_valid = 1'b1;
        repeat (30) cyc();
        checks++;
        if (out_q.size() < 12) begin
            errors++; $display("FAIL both_count got %0d want >=12", out_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (out_q[i] !== 128'(exp_d[i])) begin
                    errors++; $display("FAIL both_data beat %0d got %0h want %0h", i, out_q[i], exp_d[i]);
                end
`ifdef STREAM_ARB_SRC_TAG_EN
                checks++;
                if (src_q[i] !== exp_s[i]) begin
                    errors++; $display("FAIL both_src beat %0d got %b want %b", i, src_q[i], exp_s[i]);
                end
`else
                if (exp_s[i] && out_q[i][7:4] !== 4'hB) begin
                    checks++; errors++; $display("FAIL both_owner beat %0d got %0h want B-prefixed", i, out_q[i]);
                end
`endif
            end
        end
        checks++;
        if (d1 - 'hB0 < 8) begin errors++; $display("FAIL both_starve s1 beats got %0d want >=8", d1 - 'hB0); end
        s0i_valid = 1'b0; s1i_valid = 1'b0;
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        do_reset();
        set_src(1, 0);
        s0i_valid = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (s1o_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL stall_timeout got no valid want valid within 20 cycles");
        end else begin
            s1o_rdy = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checks++; if (s1o_data !== 128'd1) begin errors++; $display("FAIL stall_data got %0h want 1", s1o_data); end
                checks++; if (s1o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", s1o_valid); end
                checks++; if (s0i_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy got %b want 0", s0i_rdy); end
                @(posedge clk);
                #1;
            end
            s1o_rdy = 1'b1;
            repeat (12) cyc();
            checks++;
            if (out_q.size() < 6) begin
                errors++; $display("FAIL stall_count got %0d want >=6", out_q.size());
            end else begin
                for (int i = 0; i < 6; i++) begin
                    checks++;
                    if (out_q[i] !== 128'(i + 1)) begin
                        errors++; $display("FAIL stall_order beat %0d got %0h want %0h", i, out_q[i], i + 1);
                    end
                end
            end
        end
        s0i_valid = 1'b0;
    endtask

    task automatic test_release();
        int exp_d[4] = '{'hA0, 'hA1, 'hB0, 'hB1};
        do_reset();
        set_src('hA0, 'hB0);
        s0i_valid = 1'b1; s1i_valid = 1'b1;
        for (int i = 0; i < 20 && d0 != 'hA2; i++) cyc();
        checks++;
        if (d0 != 'hA2) begin errors++; $display("FAIL release_timeout got %0h want A2", d0); end
        s0i_valid = 1'b0;
        cyc();
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL release_state got %0d want 0", dut.r_state); end
        checks++; if (dut.r_rr !== 1'b1) begin errors++; $display("FAIL release_rr got %b want 1", dut.r_rr); end
        cyc();
        checks++; if (dut.r_state !== GNT1) begin errors++; $display("FAIL release_next got %0d want 2", dut.r_state); end
        repeat (8) cyc();
        checks++;
        if (out_q.size() < 4) begin
            errors++; $display("FAIL release_count got %0d want >=4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_q[i] !== 128'(exp_d[i])) begin
                    errors++; $display("FAIL release_data beat %0d got %0h want %0h", i, out_q[i], exp_d[i]);
                end
            end
        end
        s1i_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_src(1, 0);
        s0i_valid = 1'b1;
        repeat (4) cyc();
        checks++; if (s1o_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", s1o_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (s0i_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy_low got %b want 0", s0i_rdy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (s1o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", s1o_valid); end
        checks++; if (s0i_rdy !== 1'b0) begin errors++; $display("FAIL midrst_s0_rdy got %b want 0", s0i_rdy); end
        checks++; if (s1i_rdy !== 1'b0) begin errors++; $display("FAIL midrst_s1_rdy got %b want 0", s1i_rdy); end
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL midrst_state got %0d want 0", dut.r_state); end
        s0i_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_both();
        test_stall();
        test_release();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_arb2.md
STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum beats granted to one source per arbitration (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports s0i_valid (input, 1), s0i_rdy (output, 1) and s0i_data (input, 128): stream #0 into the block.
REQ-005 The block SHALL have ports s1i_valid (input, 1), s1i_rdy (output, 1) and s1i_data (input, 128): stream #1 into the block.
REQ-006 The block SHALL have ports s1o_valid (output, 1), s1o_rdy (input, 1) and s1o_data (output, 128): the shared output stream.

Function
REQ-007 The FSM SHALL have exactly three states, IDLE, GNT0 and GNT1, and SHALL enter IDLE on reset.
REQ-008 IDLE: if only source k has valid=1, the next state SHALL be GNTk.
REQ-009 IDLE: if both sources are valid, the next state SHALL be GNT of the source named by the round-robin pointer rr; rr SHALL reset to 0.
REQ-010 In IDLE, s0i_rdy and s1i_rdy SHALL both be 0, giving a one-cycle arbitration bubble.
REQ-011 In GNTk, sk_rdy SHALL be (~s1o_valid | s1o_rdy), and the other source's rdy SHALL be 0.
REQ-012 A beat SHALL be accepted when sk_valid & sk_rdy; on acceptance, s1o_data SHALL load sk_data and s1o_valid SHALL be 1 on the next cycle (latency 1).
REQ-013 When s1o_valid=1 and s1o_rdy=0, s1o_data and s1o_valid SHALL hold unchanged.
REQ-014 When s1o_rdy=1 and no beat is accepted in that cycle, s1o_valid SHALL go to 0 on the next cycle.
REQ-015 beat_cnt (8 bits) SHALL clear on entry to GNTk and increment on each accepted beat.
REQ-016 GNTk SHALL go to IDLE and set rr to 1-k after the beat that makes beat_cnt equal BURST_MAX.
REQ-017 GNTk SHALL also go to IDLE and set rr to 1-k in any cycle where sk_rdy=1 and sk_valid=0 (early release).
REQ-018 When the BURST_MAX limit and early release coincide, the block SHALL take a single transition to IDLE; rr SHALL never skip.
REQ-019 When only one source requests, it SHALL be re-granted after each bubble, giving a sustained rate of BURST_MAX beats per BURST_MAX+1 cycles.
REQ-020 No beat SHALL be duplicated, dropped or reordered within a source.

Reset
REQ-021 While rst_n=0 at a clk edge, the block SHALL set state=IDLE, rr=0, beat_cnt=0 and s1o_valid=0.
REQ-022 While rst_n=0 at a clk edge, s0i_rdy and s1i_rdy SHALL be 0; s1o_data is don't-care.
REQ-023 Reset asserted mid-burst SHALL discard any held output beat with no further handshake.

Configuration
REQ-024 The block SHALL support the macro STREAM_ARB_SRC_TAG_EN.
REQ-025 With STREAM_ARB_SRC_TAG_EN defined, the block SHALL add output port s1o_src (1 bit), registered with s1o_data, giving the source index of the held beat, and reset to 0.
REQ-026 Without STREAM_ARB_SRC_TAG_EN, port s1o_src and its register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 The state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the 128-bit data width constant SHALL reside in shared package stream_pkg.
REQ-028 The output register (valid/data/src, hold on stall) SHALL be sub-module stream_reg_slice, instantiated once; arbitration and counting SHALL stay in stream_arb2.

Verification
REQ-029 Reset, then s0i_valid=1 with data 1,2,3,… and s1o_rdy=1 -> first beat on s1o at cycle 3 after reset release, and beats 1-4 then a one-cycle gap then 5-8.
REQ-030 Both sources valid continuously (s0 data 0xA0.., s1 data 0xB0..) -> s1o carries A0-A3, B0-B3, A4-A7, and no source starves.
REQ-031 Granted s0, s1o_rdy=0 for 5 cycles after the first beat -> s1o_data stays stable at the first beat, s0i_rdy=0, and no beat is lost when s1o_rdy returns to 1.
REQ-032 s0 drops valid after 2 beats while s1 is valid -> release to IDLE, rr=1, and the next grant goes to s1.
REQ-033 rst_n=0 for one cycle mid-burst with s1o_valid=1 -> next cycle s1o_valid=0, both rdy=0 and state=IDLE.
REQ-034 With STREAM_ARB_SRC_TAG_EN defined and the REQ-030 traffic -> s1o_src reads 0,0,0,0,1,1,1,1 in step with the data.
